// File: rtl/pp_align_pipe.sv
// Multi-lane partial-product aligner: right-shifts each lane to a shared max exponent
// through a two-stage valid/ready pipeline, with sticky, exponent-error flags and an error counter.
module pp_align_pipe #(
    parameter int LANES   = 4,
    parameter int MANT_W  = 3,
    parameter int ALIGN_W = 14,
    parameter int EXP_W   = 6,
    parameter int QF_W    = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [LANES*(MANT_W+1)-1:0]   i_denorm_pp,
    input  logic [LANES*EXP_W-1:0]        i_exp,
    input  logic [EXP_W-1:0]              i_max_exp,
    input  logic [QF_W-1:0]               i_Q_frac,
    input  logic                          i_cnt_clr,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [LANES*(ALIGN_W+1)-1:0]  o_align_pp,
    output logic [LANES-1:0]              o_sticky,
    output logic [LANES-1:0]              o_err,
    output logic [QF_W-1:0]               o_Q_frac,
    output logic [EXP_W-1:0]              o_max_exp,
    output logic [15:0]                   o_err_cnt
);

    localparam int PP_W  = MANT_W + 1;
    localparam int OUT_W = ALIGN_W + 1;
    localparam int CNT_W = 16;
    localparam logic [ALIGN_W-1:0] ONES = {ALIGN_W{1'b1}};

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic                             s1_v_r;
    logic                             s2_v_r;
    logic                             s1_adv_s;
    logic                             s2_adv_s;
    logic [LANES-1:0][ALIGN_W-1:0]    c_coarse_s;
    logic [LANES-1:0][ALIGN_W-1:0]    s1_coarse_r;
    logic [LANES-1:0][1:0]            c_fine_s;
    logic [LANES-1:0][1:0]            s1_fine_r;
    logic [LANES-1:0]                 c_sign_s;
    logic [LANES-1:0]                 c_err_s;
    logic [LANES-1:0]                 c_stk_s;
    logic [LANES-1:0]                 s1_sign_r;
    logic [LANES-1:0]                 s1_err_r;
    logic [LANES-1:0]                 s1_stk_r;
    logic [QF_W-1:0]                  s1_qf_r;
    logic [EXP_W-1:0]                 s1_mexp_r;
    logic [LANES-1:0][OUT_W-1:0]      f_align_s;
    logic [LANES-1:0][OUT_W-1:0]      s2_align_r;
    logic [LANES-1:0]                 f_stk_s;
    logic [LANES-1:0]                 s2_stk_r;
    logic [LANES-1:0]                 s2_err_r;
    logic [QF_W-1:0]                  s2_qf_r;
    logic [EXP_W-1:0]                 s2_mexp_r;
    logic [CNT_W-1:0]                 err_cnt_r;
    logic [CNT_W:0]                   cnt_sum_s;

    // A stage may load when empty or when its current beat moves on this cycle.
    assign s2_adv_s = !s2_v_r || i_ready;
    assign s1_adv_s = !s1_v_r || s2_adv_s;
    assign o_ready  = !i_rst && s1_adv_s;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [MANT_W-1:0]  mant_s;
        logic [ALIGN_W-1:0] full_s;
        logic [EXP_W:0]     d_s;
        logic [EXP_W-1:0]   camt_s;
        logic [ALIGN_W-1:0] fine_mag_s;

        assign mant_s  = i_denorm_pp[k*PP_W +: MANT_W];
        assign full_s  = {mant_s, {(ALIGN_W-MANT_W){1'b0}}};
        assign d_s     = {1'b0, i_max_exp} - {1'b0, i_exp[k*EXP_W +: EXP_W]};
        assign camt_s  = {d_s[EXP_W-1:2], 2'b00};

        // A borrow in d_s flags exp > max_exp; such a lane contributes nothing.
        assign c_sign_s[k]   = i_denorm_pp[k*PP_W + MANT_W];
        assign c_err_s[k]    = d_s[EXP_W];
        assign c_coarse_s[k] = d_s[EXP_W] ? {ALIGN_W{1'b0}} : (full_s >> camt_s);
        assign c_stk_s[k]    = !d_s[EXP_W] && (|(full_s & ~(ONES << camt_s)));
        assign c_fine_s[k]   = d_s[EXP_W] ? 2'b00 : d_s[1:0];

        assign fine_mag_s    = s1_coarse_r[k] >> s1_fine_r[k];
        assign f_stk_s[k]    = s1_stk_r[k] | (|(s1_coarse_r[k] & ~(ONES << s1_fine_r[k])));
        assign f_align_s[k]  = s1_sign_r[k] ? (~{1'b0, fine_mag_s} + {{ALIGN_W{1'b0}}, 1'b1})
                                            : {1'b0, fine_mag_s};
    end

    // Stage 1 register: coarse shift, partial sticky, error flags and sideband.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_r      <= 1'b0;
            s1_coarse_r <= {(LANES*ALIGN_W){1'b0}};
            s1_fine_r   <= {(LANES*2){1'b0}};
            s1_sign_r   <= {LANES{1'b0}};
            s1_err_r    <= {LANES{1'b0}};
            s1_stk_r    <= {LANES{1'b0}};
            s1_qf_r     <= {QF_W{1'b0}};
            s1_mexp_r   <= {EXP_W{1'b0}};
        end else if (s1_adv_s) begin
            s1_v_r <= i_valid;
            if (i_valid) begin
                s1_coarse_r <= c_coarse_s;
                s1_fine_r   <= c_fine_s;
                s1_sign_r   <= c_sign_s;
                s1_err_r    <= c_err_s;
                s1_stk_r    <= c_stk_s;
                s1_qf_r     <= i_Q_frac;
                s1_mexp_r   <= i_max_exp;
            end
        end
    end

    // Stage 2 register: fine shift, final sticky and negation; drives every output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_v_r     <= 1'b0;
            s2_align_r <= {(LANES*OUT_W){1'b0}};
            s2_stk_r   <= {LANES{1'b0}};
            s2_err_r   <= {LANES{1'b0}};
            s2_qf_r    <= {QF_W{1'b0}};
            s2_mexp_r  <= {EXP_W{1'b0}};
        end else if (s2_adv_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_align_r <= f_align_s;
                s2_stk_r   <= f_stk_s;
                s2_err_r   <= s1_err_r;
                s2_qf_r    <= s1_qf_r;
                s2_mexp_r  <= s1_mexp_r;
            end
        end
    end

    assign cnt_sum_s = {1'b0, err_cnt_r} + {1'b0, popcount(s2_err_r)};

    // Saturating error-event counter; a clear discards the same-cycle beat's errors.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (i_cnt_clr) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (s2_v_r && i_ready) begin
            err_cnt_r <= cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign o_valid    = s2_v_r;
    assign o_align_pp = s2_align_r;
    assign o_sticky   = s2_stk_r;
    assign o_err      = s2_err_r;
    assign o_Q_frac   = s2_qf_r;
    assign o_max_exp  = s2_mexp_r;
    assign o_err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_pp_align_pipe.sv
// Scoreboard bench for pp_align_pipe: per-scenario tasks push expected beats on accept
// and compare them against beats captured at each output handshake.
module tb_pp_align_pipe;

    localparam int LANES   = 4;
    localparam int MANT_W  = 3;
    localparam int ALIGN_W = 14;
    localparam int EXP_W   = 6;
    localparam int QF_W    = 5;

    typedef struct packed {
        logic [59:0] align;
        logic [3:0]  sticky;
        logic [3:0]  err;
        logic [4:0]  qf;
        logic [5:0]  mexp;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_denorm_pp;
    logic [23:0] i_exp;
    logic [5:0]  i_max_exp;
    logic [4:0]  i_Q_frac;
    logic        i_cnt_clr;
    logic        o_valid;
    logic        i_ready;
    logic [59:0] o_align_pp;
    logic [3:0]  o_sticky;
    logic [3:0]  o_err;
    logic [4:0]  o_Q_frac;
    logic [5:0]  o_max_exp;
    logic [15:0] o_err_cnt;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc_cnt = 0;
    int    last_acc_cyc = 0;
    bit    rnd_ready = 1'b0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    beat_t mon_b;

    always #5 i_clk = ~i_clk;

    pp_align_pipe #(
        .LANES(LANES), .MANT_W(MANT_W), .ALIGN_W(ALIGN_W), .EXP_W(EXP_W), .QF_W(QF_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_denorm_pp(i_denorm_pp), .i_exp(i_exp), .i_max_exp(i_max_exp),
        .i_Q_frac(i_Q_frac), .i_cnt_clr(i_cnt_clr), .o_valid(o_valid), .i_ready(i_ready),
        .o_align_pp(o_align_pp), .o_sticky(o_sticky), .o_err(o_err),
        .o_Q_frac(o_Q_frac), .o_max_exp(o_max_exp), .o_err_cnt(o_err_cnt)
    );

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    // capture every output handshake
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            mon_b.align  = o_align_pp;
            mon_b.sticky = o_sticky;
            mon_b.err    = o_err;
            mon_b.qf     = o_Q_frac;
            mon_b.mexp   = o_max_exp;
            got_q.push_back(mon_b);
            got_cyc.push_back(cyc_cnt);
        end
    end

    // reference: integer arithmetic, magnitude then sticky by reconstruction
    function automatic beat_t model(input logic [15:0] pp, input logic [23:0] ex,
                                    input logic [5:0] mx, input logic [4:0] qf);
        beat_t b;
        int mant, full, d, mag;
        b.align = 60'd0; b.sticky = 4'd0; b.err = 4'd0; b.qf = qf; b.mexp = mx;
        for (int k = 0; k < 4; k++) begin
            mant = int'(pp[k*4 +: 3]);
            full = mant * 2048;
            if (ex[k*6 +: 6] > mx) begin
                b.err[k] = 1'b1;
            end else begin
                d = int'(mx) - int'(ex[k*6 +: 6]);
                if (d >= 14) begin
                    mag = 0;
                    b.sticky[k] = (mant != 0);
                end else begin
                    mag = full >> d;
                    b.sticky[k] = ((mag << d) != full);
                end
                if (pp[k*4+3]) mag = (32768 - mag) % 32768;
                b.align[k*15 +: 15] = 15'(mag);
            end
        end
        return b;
    endfunction

    task automatic apply_rdy();
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] pp, input logic [23:0] ex,
                        input logic [5:0] mx, input logic [4:0] qf);
        bit done;
        done = 1'b0;
        i_denorm_pp = pp; i_exp = ex; i_max_exp = mx; i_Q_frac = qf; i_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge i_clk);
            if (o_ready) begin
                exp_q.push_back(model(pp, ex, mx, qf));
                last_acc_cyc = cyc_cnt;
                done = 1'b1;
            end
            @(posedge i_clk); #1;
            apply_rdy();
        end
        i_valid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_accept: got no o_ready in 100 cycles, expected acceptance");
        end
    endtask

    task automatic drain(output bit ok);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin
            @(posedge i_clk); #1; apply_rdy(); t++;
        end
        repeat (4) begin @(posedge i_clk); #1; apply_rdy(); end
        ok = (got_q.size() == exp_q.size());
    endtask

    task automatic flush();
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
        i_denorm_pp = 16'd0; i_exp = 24'd0; i_max_exp = 6'd0; i_Q_frac = 5'd0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", o_ready); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
        n_tests++; if (o_align_pp !== 60'd0) begin n_fail++; $display("FAIL rst_align: got %h expected 0", o_align_pp); end
        n_tests++; if ({o_sticky, o_err} !== 8'd0) begin n_fail++; $display("FAIL rst_flags: got %h expected 0", {o_sticky, o_err}); end
        n_tests++; if ({o_Q_frac, o_max_exp} !== 11'd0) begin n_fail++; $display("FAIL rst_side: got %h expected 0", {o_Q_frac, o_max_exp}); end
        n_tests++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", o_err_cnt); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", o_ready); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        beat_t e, g;
        logic [59:0] al;
        flush();
        send(16'h0006, {4{6'd10}}, 6'd10, 5'h15);
        @(negedge i_clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: got valid %b expected 0", o_valid); end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        al = o_align_pp;
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat2: got valid %b expected 1", o_valid); end
        n_tests++; if (al !== 60'h3000) begin n_fail++; $display("FAIL basic_align: got %h expected 3000", al); end
        n_tests++; if ({o_sticky, o_err, o_Q_frac, o_max_exp} !== {4'd0, 4'd0, 5'h15, 6'd10}) begin
            n_fail++; $display("FAIL basic_side: got %h expected %h", {o_sticky, o_err, o_Q_frac, o_max_exp}, {4'd0, 4'd0, 5'h15, 6'd10});
        end
        @(posedge i_clk); #1;
        // lane1 negative d=1, lane2 exponent error
        send(16'h05F0, {6'd10, 6'd12, 6'd9, 6'd10}, 6'd10, 5'h0A);
        drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        if (got_q.size() == 2) begin
            al = got_q[1].align;
            n_tests++; if (al[29:15] !== 15'h6400) begin n_fail++; $display("FAIL lane1_neg: got %h expected 6400", al[29:15]); end
            n_tests++; if (got_q[1].err !== 4'b0100) begin n_fail++; $display("FAIL lane2_err: got %b expected 0100", got_q[1].err); end
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL basic_beat: got %h expected %h", g, e); end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        bit ok;
        beat_t e, g;
        int a0, gc;
        int exp_al[4] = '{6, 3, 1, 0};
        logic [3:0] exp_st = 4'b1100;
        flush();
        send(16'h0006, {18'd0, 6'd9}, 6'd20, 5'd1);
        a0 = last_acc_cyc;
        send(16'h0006, {18'd0, 6'd8}, 6'd20, 5'd2);
        send(16'h0006, {18'd0, 6'd7}, 6'd20, 5'd3);
        send(16'h0006, {18'd0, 6'd0}, 6'd20, 5'd4);
        drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 4 && got_q.size() != 0 && exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gc = got_cyc.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_beat%0d: got %h expected %h", i, g, e); end
            n_tests++; if ({g.align[14:0], g.sticky[0]} !== {15'(exp_al[i]), exp_st[i]}) begin
                n_fail++; $display("FAIL b2b_lane0_%0d: got %h/%b expected %0d/%b", i, g.align[14:0], g.sticky[0], exp_al[i], exp_st[i]);
            end
            n_tests++; if (gc !== a0 + 2 + i) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, gc, a0 + 2 + i); end
        end
        flush();
    endtask

    task automatic test_stall();
        bit ok;
        int idx;
        beat_t e, g;
        logic [78:0] snap;
        flush();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            i_ready = (c >= 5);
            i_valid = (idx < 4);
            i_denorm_pp = {12'd0, 4'(idx + 4)};
            i_exp = {18'd0, 6'(10 - idx)};
            i_max_exp = 6'd10;
            i_Q_frac = 5'(3 * idx + 3);
            @(negedge i_clk);
            if (c < 5) begin
                n_tests++; if (o_ready !== (c < 2)) begin n_fail++; $display("FAIL stall_ready_c%0d: got %b expected %b", c, o_ready, (c < 2)); end
            end
            if (c == 2) begin
                snap = {o_align_pp, o_sticky, o_err, o_Q_frac, o_max_exp};
                n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", o_valid); end
            end
            if (c == 3 || c == 4) begin
                n_tests++; if ({o_align_pp, o_sticky, o_err, o_Q_frac, o_max_exp} !== snap || o_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_hold_c%0d: got %h expected %h", c, {o_align_pp, o_sticky, o_err, o_Q_frac, o_max_exp}, snap);
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_denorm_pp, i_exp, i_max_exp, i_Q_frac));
                idx++;
            end
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        drain(ok);
        n_tests++; if (!ok || got_q.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d beats expected 4", got_q.size()); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL stall_order: got %h expected %h", g, e); end
        end
        flush();
    endtask

    task automatic test_random();
        bit ok;
        beat_t e, g;
        flush();
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(16'($urandom), 24'($urandom), 6'($urandom_range(0, 63)), 5'($urandom));
        end
        drain(ok);
        rnd_ready = 1'b0; i_ready = 1'b1;
        drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL rand_beat: got %h expected %h", g, e); end
        end
        flush();
    endtask

    task automatic test_err_cnt();
        bit ok;
        beat_t e, g;
        flush();
        i_ready = 1'b1;
        i_cnt_clr = 1'b1; @(posedge i_clk); #1; i_cnt_clr = 1'b0;
        n_tests++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %h expected 0", o_err_cnt); end
        send(16'h5555, {6'd10, 6'd12, 6'd10, 6'd10}, 6'd10, 5'd7);
        drain(ok);
        n_tests++; if (o_err_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_inc: got %h expected 1", o_err_cnt); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL err_beat: got %h expected %h", g, e); end
        end
        flush();
        i_denorm_pp = 16'h5555; i_exp = {4{6'd63}}; i_max_exp = 6'd0; i_valid = 1'b1;
        repeat (16400) begin @(posedge i_clk); #1; end
        i_valid = 1'b0;
        repeat (4) begin @(posedge i_clk); #1; end
        n_tests++; if (o_err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat: got %h expected FFFF", o_err_cnt); end
        send(16'h0000, {4{6'd40}}, 6'd1, 5'd2);
        drain(ok);
        n_tests++; if (o_err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat_hold: got %h expected FFFF", o_err_cnt); end
        flush();
        send(16'h1111, {4{6'd40}}, 6'd1, 5'd3);
        @(posedge i_clk); #1;
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL clr_beat_valid: got %b expected 1", o_valid); end
        i_cnt_clr = 1'b1;
        @(posedge i_clk); #1;
        i_cnt_clr = 1'b0;
        n_tests++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clr_priority: got %h expected 0", o_err_cnt); end
        drain(ok);
        flush();
    endtask

    task automatic test_reset_flush();
        bit ok;
        flush();
        i_ready = 1'b1;
        send(16'h0000, {6'd10, 6'd12, 6'd10, 6'd10}, 6'd10, 5'd9);
        drain(ok);
        n_tests++; if (o_err_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_pre_cnt: got %h expected 1", o_err_cnt); end
        flush();
        i_ready = 1'b0;
        send(16'h0006, {4{6'd12}}, 6'd10, 5'd21);
        send(16'h0007, {4{6'd12}}, 6'd10, 5'd22);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_ready = 1'b1;
        exp_q.delete();
        @(negedge i_clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", o_valid); end
        n_tests++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt: got %h expected 0", o_err_cnt); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", o_ready); end
        repeat (6) begin @(posedge i_clk); #1; end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_ghost: got %0d beats expected 0", got_q.size()); end
        flush();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_random();
        test_err_cnt();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
